fetch_responder: RTL and testbench

FETCH_RESPONDER -- requirements
Module: fetch_responder

---
 rtl/fetch_responder.sv | 160 ++++++++++++++++
 tb/tb_fetch_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_responder.sv
// In-order instruction fetch responder: queues word addresses and reads them from Avalon-MM memory.
// Optional last-word bypass register is built when FETCH_RESPONDER_LAST_HIT_EN is defined.
module fetch_responder #(
  parameter int DEPTH_ORDER = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic [29:0] addr,
  output logic        fetched,
  output logic [31:0] fetch_data,
  output logic        mem_read,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  input  logic        inval,
  output logic        overflow
);

  localparam int DEPTH = 2 ** DEPTH_ORDER;
  localparam logic [DEPTH_ORDER:0] FULL = (DEPTH_ORDER + 1)'(DEPTH);
  localparam logic [DEPTH_ORDER:0] C_ONE = 1;
  localparam logic [DEPTH_ORDER:0] C_ZERO = 0;
  localparam logic [DEPTH_ORDER-1:0] P_ONE = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [29:0]            r_fifo [DEPTH];
  logic [DEPTH_ORDER-1:0] r_wptr;
  logic [DEPTH_ORDER-1:0] r_rptr;
  logic [DEPTH_ORDER:0]   r_count;
  logic [DEPTH_ORDER:0]   w_count_nxt;
  logic                   r_fetched;
  logic [31:0]            r_data;
  logic                   r_ovf;

  logic        w_head_valid;
  logic [29:0] w_head;
  logic        w_pop;
  logic        w_full;
  logic        w_req;
  logic        w_push;
  logic        w_drop;
  logic        w_hit;
  logic [31:0] w_hit_data;

  assign w_head       = r_fifo[r_rptr];
  assign w_head_valid = (r_state == ST_READ);
  assign w_pop        = w_head_valid && !mem_waitrequest;
  assign w_full       = (r_count == FULL);
  assign w_req        = fetch && !w_hit;
  // A full queue still takes a request when the head retires the same cycle
  assign w_push       = w_req && (!w_full || w_pop);
  assign w_drop       = w_req && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + C_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - C_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (w_pop && (w_count_nxt == C_ZERO)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_fetched <= 1'b0;
      r_data    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_fetched <= w_pop || w_hit;
      if (w_push) begin
        r_wptr <= r_wptr + P_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + P_ONE;
        r_data <= mem_readdata;
      end else if (w_hit) begin
        r_data <= w_hit_data;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Entry storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo[r_wptr] <= addr;
    end
  end

`ifdef FETCH_RESPONDER_LAST_HIT_EN
  logic        r_lw_valid;
  logic [29:0] r_lw_addr;
  logic [31:0] r_lw_data;

  assign w_hit = fetch && (r_state == ST_IDLE) && (r_count == C_ZERO)
              && r_lw_valid && !inval && (addr == r_lw_addr);
  assign w_hit_data = r_lw_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lw_valid <= 1'b0;
      r_lw_addr  <= '0;
      r_lw_data  <= '0;
    end else begin
      if (w_pop) begin
        r_lw_addr <= w_head;
        r_lw_data <= mem_readdata;
      end
      if (inval) begin
        r_lw_valid <= 1'b0;
      end else if (w_pop) begin
        r_lw_valid <= 1'b1;
      end
    end
  end
`else
  logic w_unused_inval;

  assign w_hit          = 1'b0;
  assign w_hit_data     = '0;
  assign w_unused_inval = inval;
`endif

  assign fetched    = r_fetched;
  assign fetch_data = r_data;
  assign mem_read   = w_head_valid;
  assign mem_addr   = w_head_valid ? w_head : '0;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder with a combinational memory model.
// Last-word bypass checks follow FETCH_RESPONDER_LAST_HIT_EN.
module tb_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch;
  logic [29:0] addr;
  logic        fetched;
  logic [31:0] fetch_data;
  logic        mem_read;
  logic [29:0] mem_addr;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        inval;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] got_q [$];

  fetch_responder #(.DEPTH_ORDER(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch           (fetch),
    .addr            (addr),
    .fetched         (fetched),
    .fetch_data      (fetch_data),
    .mem_read        (mem_read),
    .mem_addr        (mem_addr),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .inval           (inval),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [29:0] a);
    if (a == 30'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_readdata = memf(mem_addr);

  always @(negedge clk) begin
    if (fetched) got_q.push_back(fetch_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fetch = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic check_q(input string tag, input logic [29:0] base,
                         input int n);
    check_eq({tag, "_cnt"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check_eq($sformatf("%s_d%0d", tag, i), got_q[i],
               memf(base + 30'(i)));
  endtask

  initial begin
    rst = 1'b1;
    fetch = 1'b0;
    addr = '0;
    mem_waitrequest = 1'b0;
    inval = 1'b0;
    do_reset();

    check_eq("rst_fetched", 32'(fetched), 0);
    check_eq("rst_mem_read", 32'(mem_read), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_fetch_data", fetch_data, 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);

    // single read, minimum latency
    fetch = 1'b1;
    addr = 30'h100;
    cyc();
    fetch = 1'b0;
    check_eq("lat_mem_read", 32'(mem_read), 1);
    check_eq("lat_mem_addr", 32'(mem_addr), 32'h100);
    check_eq("lat_early", 32'(fetched), 0);
    cyc();
    check_eq("lat_fetched", 32'(fetched), 1);
    check_eq("lat_data", fetch_data, 32'hDEADBEEF);
    check_eq("lat_idle", 32'(mem_read), 0);
    cyc();
    check_eq("hold_fetched", 32'(fetched), 0);
    check_eq("hold_data", fetch_data, 32'hDEADBEEF);

    // four requests with a stalled first read
    got_q.delete();
    mem_waitrequest = 1'b1;
    fetch = 1'b1;
    addr = 30'h10;
    cyc();
    addr = 30'h11;
    cyc();
    addr = 30'h12;
    cyc();
    addr = 30'h13;
    check_eq("stall_mem_read", 32'(mem_read), 1);
    check_eq("stall_mem_addr", 32'(mem_addr), 32'h10);
    cyc();
    fetch = 1'b0;
    mem_waitrequest = 1'b0;
    idle(8);
    check_q("inord", 30'h10, 4);
    check_eq("inord_ovf", 32'(overflow), 0);

    // fifth request into a full stalled queue is dropped
    got_q.delete();
    mem_waitrequest = 1'b1;
    fetch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr = 30'h30 + 30'(i);
      cyc();
    end
    fetch = 1'b0;
    check_eq("drop_ovf", 32'(overflow), 1);
    mem_waitrequest = 1'b0;
    idle(8);
    check_q("drop", 30'h30, 4);
    check_eq("drop_ovf_sticky", 32'(overflow), 1);
    do_reset();
    check_eq("drop_ovf_clr", 32'(overflow), 0);

    // full queue accepts a request in a cycle that also pops
    got_q.delete();
    mem_waitrequest = 1'b1;
    fetch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 30'h60 + 30'(i);
      cyc();
    end
    addr = 30'h64;
    mem_waitrequest = 1'b0;
    cyc();
    fetch = 1'b0;
    idle(8);
    check_q("fullpop", 30'h60, 5);
    check_eq("fullpop_ovf", 32'(overflow), 0);

    // reset while reading abandons queued work
    got_q.delete();
    mem_waitrequest = 1'b1;
    fetch = 1'b1;
    addr = 30'h40;
    cyc();
    addr = 30'h41;
    cyc();
    fetch = 1'b0;
    check_eq("rstrd_busy", 32'(mem_read), 1);
    rst = 1'b1;
    fetch = 1'b1;
    addr = 30'h42;
    cyc();
    rst = 1'b0;
    fetch = 1'b0;
    check_eq("rstrd_mem_read", 32'(mem_read), 0);
    check_eq("rstrd_fetched", 32'(fetched), 0);
    mem_waitrequest = 1'b0;
    idle(4);
    check_eq("rstrd_none", 32'(got_q.size()), 0);
    fetch = 1'b1;
    addr = 30'h50;
    cyc();
    fetch = 1'b0;
    check_eq("rstrd_next_rd", 32'(mem_read), 1);
    check_eq("rstrd_next_addr", 32'(mem_addr), 32'h50);
    cyc();
    check_eq("rstrd_next_f", 32'(fetched), 1);
    check_eq("rstrd_next_d", fetch_data, memf(30'h50));

    // repeat fetch of the same word
    do_reset();
    fetch = 1'b1;
    addr = 30'h20;
    cyc();
    idle(2);
    fetch = 1'b1;
    addr = 30'h20;
    cyc();
    fetch = 1'b0;
`ifdef FETCH_RESPONDER_LAST_HIT_EN
    check_eq("hit_fetched", 32'(fetched), 1);
    check_eq("hit_data", fetch_data, memf(30'h20));
    check_eq("hit_no_read", 32'(mem_read), 0);
    cyc();
    check_eq("hit_no_read2", 32'(mem_read), 0);
    check_eq("hit_single", 32'(fetched), 0);
`else
    check_eq("rep_mem_read", 32'(mem_read), 1);
    check_eq("rep_mem_addr", 32'(mem_addr), 32'h20);
    check_eq("rep_early", 32'(fetched), 0);
    cyc();
    check_eq("rep_fetched", 32'(fetched), 1);
    check_eq("rep_data", fetch_data, memf(30'h20));
`endif
    idle(2);
    inval = 1'b1;
    cyc();
    inval = 1'b0;
    fetch = 1'b1;
    addr = 30'h20;
    cyc();
    fetch = 1'b0;
    check_eq("inv_mem_read", 32'(mem_read), 1);
    check_eq("inv_early", 32'(fetched), 0);
    cyc();
    check_eq("inv_fetched", 32'(fetched), 1);
    check_eq("inv_data", fetch_data, memf(30'h20));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
